// File: rtl/alu_operand_prep_if.sv
// Handshake bundle for the ALU operand-preparation stage: upstream raw operands
// with zx/nx/zy/ny controls, downstream prepared operands and a delivery counter.
interface alu_operand_prep_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             in_zx;
    logic             in_nx;
    logic             in_zy;
    logic             in_ny;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_x;
    logic [WIDTH-1:0] out_y;
    logic [7:0]       beat_count;

    modport slave (
        input  in_valid, in_x, in_y, in_zx, in_nx, in_zy, in_ny, out_ready,
        output in_ready, out_valid, out_x, out_y, beat_count
    );

    modport master (
        output in_valid, in_x, in_y, in_zx, in_nx, in_zy, in_ny, out_ready,
        input  in_ready, out_valid, out_x, out_y, beat_count
    );
endinterface

// File: rtl/alu_operand_prep.sv
// Registered zero/negate operand stage feeding the ALU core, with a main
// register plus one skid register so back-pressure costs no throughput.
module alu_operand_prep #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_prep_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main_x;
    logic [WIDTH-1:0] r_main_y;
    logic [WIDTH-1:0] r_skid_x;
    logic [WIDTH-1:0] r_skid_y;
    logic [7:0]       r_beat_count;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_acc;
    logic             w_dlv;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_move_skid;
    logic [WIDTH-1:0] w_prep_x;
    logic [WIDTH-1:0] w_prep_y;

    // Zero first, then bitwise NOT; no carry, no width growth.
    function automatic logic [WIDTH-1:0] prep_operand(
        input logic [WIDTH-1:0] raw,
        input logic             zero,
        input logic             neg
    );
        logic [WIDTH-1:0] v;
        v = zero ? {WIDTH{1'b0}} : raw;
        return neg ? ~v : v;
    endfunction

    assign w_in_ready  = (r_state != ST_FULL);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_acc       = bus.in_valid & w_in_ready;
    assign w_dlv       = w_out_valid & bus.out_ready;
    assign w_prep_x    = prep_operand(bus.in_x, bus.in_zx, bus.in_nx);
    assign w_prep_y    = prep_operand(bus.in_y, bus.in_zy, bus.in_ny);

    // Next-state and storage-steering decode for the skid buffer.
    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_move_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_load_main = 1'b1;
                    w_state_nxt = ST_ONE;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_acc && !w_dlv) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_acc && w_dlv) begin
                    w_load_main = 1'b1;
                    w_state_nxt = ST_ONE;
                end else if (w_dlv) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_FULL: begin
                if (w_dlv) begin
                    w_move_skid = 1'b1;
                    w_state_nxt = ST_ONE;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State, operand storage and delivery counter; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_main_x     <= {WIDTH{1'b0}};
            r_main_y     <= {WIDTH{1'b0}};
            r_skid_x     <= {WIDTH{1'b0}};
            r_skid_y     <= {WIDTH{1'b0}};
            r_beat_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main) begin
                r_main_x <= w_prep_x;
                r_main_y <= w_prep_y;
            end else if (w_move_skid) begin
                r_main_x <= r_skid_x;
                r_main_y <= r_skid_y;
            end
            if (w_load_skid) begin
                r_skid_x <= w_prep_x;
                r_skid_y <= w_prep_y;
            end
            if (w_dlv) begin
                r_beat_count <= r_beat_count + 8'd1;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_x      = r_main_x;
    assign bus.out_y      = r_main_y;
    assign bus.beat_count = r_beat_count;

endmodule

// File: tb/tb_alu_operand_prep.sv
// Directed and randomised checks of the operand-prep stage: transform values,
// skid-buffer back-pressure, streaming throughput, FIFO ordering and reset.
module tb_alu_operand_prep;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    alu_operand_prep_if #(.WIDTH(16)) bus ();

    alu_operand_prep #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_prep(input logic [15:0] raw, input logic z, input logic n);
        logic [15:0] v;
        v = z ? 16'h0000 : raw;
        return n ? ~v : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic zx, input logic nx, input logic zy, input logic ny);
        bus.in_valid = v;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_zx    = zx;
        bus.in_nx    = nx;
        bus.in_zy    = zy;
        bus.in_ny    = ny;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 16'hBEEF, 16'hCAFE, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_x !== 16'h0000) begin n_bad++; $display("FAIL reset_out_x got %h want 0000", bus.out_x); end
        n_cmp++; if (bus.out_y !== 16'h0000) begin n_bad++; $display("FAIL reset_out_y got %h want 0000", bus.out_y); end
        n_cmp++; if (bus.beat_count !== 8'd0) begin n_bad++; $display("FAIL reset_beat_count got %0d want 0", bus.beat_count); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_no_capture got %b want 0", bus.out_valid); end
    endtask

    task automatic test_transform();
        do_reset();
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL xf_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_x !== 16'hFFFF) begin n_bad++; $display("FAIL xf_not0 got %h want FFFF", bus.out_x); end
        n_cmp++; if (bus.out_y !== 16'h0000) begin n_bad++; $display("FAIL xf_y_pass got %h want 0000", bus.out_y); end
        drive(1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        n_cmp++; if (bus.out_x !== 16'h0000) begin n_bad++; $display("FAIL xf_notF got %h want 0000", bus.out_x); end
        drive(1'b1, 16'hAAAA, 16'h3CC3, 1'b0, 1'b1, 1'b0, 1'b1); tick();
        n_cmp++; if (bus.out_x !== 16'h5555) begin n_bad++; $display("FAIL xf_notA got %h want 5555", bus.out_x); end
        n_cmp++; if (bus.out_y !== 16'hC33C) begin n_bad++; $display("FAIL xf_noty got %h want C33C", bus.out_y); end
        drive(1'b1, 16'h1234, 16'h9876, 1'b1, 1'b1, 1'b0, 1'b0); tick();
        n_cmp++; if (bus.out_x !== 16'hFFFF) begin n_bad++; $display("FAIL xf_zx_nx got %h want FFFF", bus.out_x); end
        n_cmp++; if (bus.out_y !== 16'h9876) begin n_bad++; $display("FAIL xf_y_raw got %h want 9876", bus.out_y); end
        drive(1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        n_cmp++; if (bus.out_x !== 16'h0000) begin n_bad++; $display("FAIL xf_zx got %h want 0000", bus.out_x); end
        n_cmp++; if (bus.out_y !== 16'h0000) begin n_bad++; $display("FAIL xf_zy got %h want 0000", bus.out_y); end
        drive(1'b1, 16'h0F0F, 16'h5678, 1'b0, 1'b0, 1'b1, 1'b1); tick();
        n_cmp++; if (bus.out_x !== 16'h0F0F) begin n_bad++; $display("FAIL xf_x_raw got %h want 0F0F", bus.out_x); end
        n_cmp++; if (bus.out_y !== 16'hFFFF) begin n_bad++; $display("FAIL xf_zy_ny got %h want FFFF", bus.out_y); end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL xf_drain got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.beat_count !== 8'd6) begin n_bad++; $display("FAIL xf_count got %0d want 6", bus.beat_count); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h1111, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_one got %b want 1", bus.in_ready); end
        drive(1'b1, 16'h2222, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.out_x !== 16'h1111) begin n_bad++; $display("FAIL bp_hold_a got %h want 1111", bus.out_x); end
        drive(1'b1, 16'h3333, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        // Control changes while stalled must not leak into the held beat C.
        bus.in_nx = 1'b1; tick(); bus.in_nx = 1'b0;
        n_cmp++; if (bus.out_x !== 16'h1111) begin n_bad++; $display("FAIL bp_stable got %h want 1111", bus.out_x); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid got %b want 1", bus.out_valid); end
        bus.out_ready = 1'b1; tick();
        n_cmp++; if (bus.out_x !== 16'h2222) begin n_bad++; $display("FAIL bp_order_b got %h want 2222", bus.out_x); end
        n_cmp++; if (bus.out_y !== 16'h0002) begin n_bad++; $display("FAIL bp_order_by got %h want 0002", bus.out_y); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back got %b want 1", bus.in_ready); end
        tick();
        n_cmp++; if (bus.out_x !== 16'h3333) begin n_bad++; $display("FAIL bp_order_c got %h want 3333", bus.out_x); end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.beat_count !== 8'd3) begin n_bad++; $display("FAIL bp_count got %0d want 3", bus.beat_count); end
    endtask

    task automatic test_streaming();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 16'(i), 16'(i) ^ 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            n_cmp++; if (bus.out_x !== 16'(i)) begin n_bad++; $display("FAIL stream_x[%0d] got %h want %h", i, bus.out_x, 16'(i)); end
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready[%0d] got %b want 1", i, bus.in_ready); end
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        n_cmp++; if (bus.beat_count !== 8'd44) begin n_bad++; $display("FAIL stream_wrap got %0d want 44", bus.beat_count); end
    endtask

    task automatic test_random();
        logic [15:0] q_x[$];
        logic [15:0] q_y[$];
        int          sent;
        int          got;
        int          cyc;
        logic        acc;
        logic        dlv;
        logic [15:0] rx;
        logic [15:0] ry;
        logic [3:0]  rc;
        do_reset();
        sent = 0; got = 0; cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            rx = 16'($urandom); ry = 16'($urandom); rc = 4'($urandom);
            drive((sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0, rx, ry, rc[0], rc[1], rc[2], rc[3]);
            bus.out_ready = 1'($urandom_range(0, 1));
            n_cmp++; if (bus.in_ready !== (q_x.size() < 2)) begin n_bad++; $display("FAIL rnd_ready cyc %0d got %b occ %0d", cyc, bus.in_ready, q_x.size()); end
            n_cmp++; if (bus.out_valid !== (q_x.size() > 0)) begin n_bad++; $display("FAIL rnd_valid cyc %0d got %b occ %0d", cyc, bus.out_valid, q_x.size()); end
            if (q_x.size() > 0) begin
                n_cmp++; if (bus.out_x !== q_x[0] || bus.out_y !== q_y[0]) begin
                    n_bad++; $display("FAIL rnd_data cyc %0d got %h/%h want %h/%h", cyc, bus.out_x, bus.out_y, q_x[0], q_y[0]);
                end
            end
            acc = bus.in_valid && (q_x.size() < 2);
            dlv = (q_x.size() > 0) && bus.out_ready;
            tick();
            cyc++;
            if (dlv) begin
                void'(q_x.pop_front()); void'(q_y.pop_front()); got++;
            end
            if (acc) begin
                q_x.push_back(model_prep(rx, rc[0], rc[1]));
                q_y.push_back(model_prep(ry, rc[2], rc[3]));
                sent++;
            end
        end
        n_cmp++; if (got != 1000) begin n_bad++; $display("FAIL rnd_timeout delivered %0d want 1000", got); end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_full();
        do_reset();
        bus.out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 16'h1010, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 16'hBBBB, 16'h2020, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rf_full got %b want 0", bus.in_ready); end
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 16'hCCCC, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        rst_n = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rf_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rf_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.beat_count !== 8'd0) begin n_bad++; $display("FAIL rf_count got %0d want 0", bus.beat_count); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rf_ghost[%0d] got %b x %h", i, bus.out_valid, bus.out_x); end
        end
        n_cmp++; if (bus.out_x !== 16'h0000) begin n_bad++; $display("FAIL rf_out_x got %h want 0000", bus.out_x); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        test_reset();
        test_transform();
        test_back_pressure();
        test_streaming();
        test_random();
        test_reset_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
